wb_port_arbiter: RTL and testbench

// - Shares the NR_WB_PORTS write-back ports among NR_WB_REQ functional-unit result streams.
// - Example streams: ALU, LSU load, CSR/misc.
// - Sits between the FU outputs and the register-file / completion write-back.
// - Removes the fixed "1 FU -> 1 WB port" mapping.
// - Each requester owns a 1-entry holding slot. A rotating round-robin grant fills the ports every cycle.

---
 rtl/wb_port_arbiter_pkg.sv | 23 ++
 rtl/wb_rr_picker.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 98 +++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: FU result payload, requester
// vectors and source-index width.
package wb_port_arbiter_pkg;

   localparam int NR_WB_REQ   = 3;
   localparam int NR_WB_PORTS = 2;
   localparam int WB_SRC_W    = (NR_WB_REQ > 1) ? $clog2(NR_WB_REQ) : 1;

   typedef logic [NR_WB_REQ-1:0] wb_req_bitvector_t;
   typedef logic [WB_SRC_W-1:0]  wb_src_idx_t;

   typedef struct packed {
      logic [7:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
   } fu_output_t;

   // Modulo-n step for an index that is at most one wrap past the end.
   function automatic int wrap_idx(input int i, input int n);
      return (i >= n) ? i - n : i;
   endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: walks valid slots from the rotation pointer
// and packs up to NR_PORTS grants onto ports 0..k with no holes.
module wb_rr_picker
   import wb_port_arbiter_pkg::*;
#(
   parameter int NR_REQ   = NR_WB_REQ,
   parameter int NR_PORTS = NR_WB_PORTS,
   parameter int IDX_W    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
   input  logic [NR_REQ-1:0]                i_valid,
   input  logic [IDX_W-1:0]                 i_rr_ptr,
   output logic [NR_PORTS-1:0][IDX_W-1:0]   o_port_idx,
   output logic [NR_PORTS-1:0]              o_port_vld,
   output logic [NR_REQ-1:0]                o_grant,
   output logic [IDX_W-1:0]                 o_last,
   output logic                             o_any
);

   always_comb begin
      int                cnt;
      logic [IDX_W-1:0]  j;
      cnt        = 0;
      j          = '0;
      o_port_idx = '0;
      o_port_vld = '0;
      o_grant    = '0;
      o_last     = '0;
      o_any      = 1'b0;
      for (int i = 0; i < NR_REQ; i++) begin
         j = IDX_W'(wrap_idx(int'(i_rr_ptr) + i, NR_REQ));
         if (i_valid[j] && (cnt < NR_PORTS)) begin
            // Comparing against each port index keeps the port select static.
            for (int k = 0; k < NR_PORTS; k++) begin
               if (cnt == k) begin
                  o_port_idx[k] = j;
                  o_port_vld[k] = 1'b1;
               end
            end
            o_grant[j] = 1'b1;
            o_last     = j;
            o_any      = 1'b1;
            cnt++;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: one holding slot per FU result stream, shared
// round-robin onto NR_PORTS registered write-back ports.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NR_REQ   = NR_WB_REQ,
   parameter int NR_PORTS = NR_WB_PORTS,
   localparam int IDX_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush_i,
   input  fu_output_t                       req_i [NR_REQ],
   input  logic [NR_REQ-1:0]                req_valid_i,
   output logic [NR_REQ-1:0]                req_ready_o,
   output fu_output_t                       wb_o [NR_PORTS],
   output logic [NR_PORTS-1:0]              wb_valid_o,
   output logic [NR_PORTS-1:0][IDX_W-1:0]   wb_src_o
);

   logic [NR_REQ-1:0]               r_slot_vld;
   fu_output_t                      r_slot_data [NR_REQ];
   logic [IDX_W-1:0]                r_rr_ptr;
   fu_output_t                      r_wb [NR_PORTS];
   logic [NR_PORTS-1:0]             r_wb_vld;
   logic [NR_PORTS-1:0][IDX_W-1:0]  r_wb_src;

   logic [NR_PORTS-1:0][IDX_W-1:0]  w_port_idx;
   logic [NR_PORTS-1:0]             w_port_vld;
   logic [NR_REQ-1:0]               w_grant;
   logic [IDX_W-1:0]                w_last;
   logic                            w_any;
   logic [NR_REQ-1:0]               w_accept;
   logic [IDX_W-1:0]                w_next_ptr;
   fu_output_t                      w_sel [NR_PORTS];

   wb_rr_picker #(
      .NR_REQ   (NR_REQ),
      .NR_PORTS (NR_PORTS),
      .IDX_W    (IDX_W)
   ) u_picker (
      .i_valid    (r_slot_vld),
      .i_rr_ptr   (r_rr_ptr),
      .o_port_idx (w_port_idx),
      .o_port_vld (w_port_vld),
      .o_grant    (w_grant),
      .o_last     (w_last),
      .o_any      (w_any)
   );

   // A slot leaving this cycle frees itself for a new result at the same edge.
   assign req_ready_o = ~r_slot_vld | w_grant;
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_next_ptr  = IDX_W'(wrap_idx(int'(w_last) + 1, NR_REQ));

   always_comb begin
      for (int k = 0; k < NR_PORTS; k++) begin
         w_sel[k] = w_port_vld[k] ? r_slot_data[w_port_idx[k]] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_vld <= '0;
         r_rr_ptr   <= '0;
         r_wb_vld   <= '0;
         r_wb_src   <= '0;
         for (int r = 0; r < NR_REQ; r++) r_slot_data[r] <= '0;
         for (int k = 0; k < NR_PORTS; k++) r_wb[k] <= '0;
      end else if (flush_i) begin
         // Held and in-flight results are dropped; the rotation keeps its place.
         r_slot_vld <= '0;
         r_wb_vld   <= '0;
         r_wb_src   <= '0;
         for (int k = 0; k < NR_PORTS; k++) r_wb[k] <= '0;
      end else begin
         for (int r = 0; r < NR_REQ; r++) begin
            if (w_accept[r]) begin
               r_slot_vld[r]  <= 1'b1;
               r_slot_data[r] <= req_i[r];
            end else if (w_grant[r]) begin
               r_slot_vld[r]  <= 1'b0;
            end
         end
         if (w_any) r_rr_ptr <= w_next_ptr;
         r_wb_vld <= w_port_vld;
         for (int k = 0; k < NR_PORTS; k++) begin
            r_wb[k]     <= w_sel[k];
            r_wb_src[k] <= w_port_vld[k] ? w_port_idx[k] : '0;
         end
      end
   end

   assign wb_o       = r_wb;
   assign wb_valid_o = r_wb_vld;
   assign wb_src_o   = r_wb_src;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of the write-back port arbiter
// (3 requesters, 2 ports) against hand-computed grant sequences.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   logic             clk;
   logic             rst;
   logic             flush;
   fu_output_t       req [3];
   logic [2:0]       req_vld;
   logic [2:0]       req_rdy;
   fu_output_t       wb [2];
   logic [1:0]       wbv;
   logic [1:0][1:0]  wb_src;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .req_i       (req),
      .req_valid_i (req_vld),
      .req_ready_o (req_rdy),
      .wb_o        (wb),
      .wb_valid_o  (wbv),
      .wb_src_o    (wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input logic v, input logic [7:0] id, input logic [31:0] d);
      req_vld[r]  = v;
      req[r].id   = id;
      req[r].rd   = 5'(r);
      req[r].data = d;
   endtask

   function automatic logic [31:0] mkdata(input logic [7:0] id);
      return {8'hC3, id, ~id, id};
   endfunction

   // Contention table, one row per check point after edge k
   logic [2:0] c_rdy [6] = '{3'b111, 3'b011, 3'b101, 3'b110, 3'b011, 3'b101};
   logic [1:0] c_wbv [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
   logic [1:0] c_s0  [6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0};
   logic [1:0] c_s1  [6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
   logic [7:0] c_id0 [6] = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h11, 8'h02};
   logic [7:0] c_id1 [6] = '{8'h00, 8'h00, 8'h10, 8'h01, 8'h21, 8'h12};

   logic [7:0] cur [3];
   logic       pend [3];
   logic [7:0] pend_id [3];
   int         age [3];
   logic       acc [3];
   logic [7:0] acc_id [3];
   logic [5:0] seq [3];

   task automatic rnd_step(input bit gen);
      int s;
      for (int r = 0; r < 3; r++) if (pend[r]) age[r]++;
      check_eq("rnd_pack", {63'd0, wbv == 2'b10}, 64'd0);
      for (int k = 0; k < 2; k++) begin
         if (wbv[k]) begin
            s = int'(wb_src[k]);
            check_eq("rnd_src_range", {63'd0, s < 3}, 64'd1);
            if (s < 3) begin
               check_eq("rnd_dup", {63'd0, pend[s]}, 64'd1);
               check_eq("rnd_id", wb[k].id, pend_id[s]);
               check_eq("rnd_data", wb[k].data, mkdata(pend_id[s]));
               check_eq("rnd_fair", {63'd0, age[s] <= 2}, 64'd1);
               pend[s] = 1'b0;
            end
         end
      end
      for (int r = 0; r < 3; r++) begin
         if (pend[r]) check_eq("rnd_wait", {63'd0, age[r] < 2}, 64'd1);
         if (acc[r]) begin
            check_eq("rnd_overwrite", {63'd0, pend[r]}, 64'd0);
            pend[r]    = 1'b1;
            pend_id[r] = acc_id[r];
            age[r]     = 0;
         end
      end
      for (int r = 0; r < 3; r++) begin
         if (!(req_vld[r] && !acc[r])) begin
            if (gen && ($urandom_range(0, 9) < 7)) begin
               seq[r]++;
               drive(r, 1'b1, {2'(r), seq[r]}, mkdata({2'(r), seq[r]}));
            end else begin
               req_vld[r] = 1'b0;
            end
         end
      end
      for (int r = 0; r < 3; r++) begin
         acc[r]    = req_vld[r] & req_rdy[r];
         acc_id[r] = req[r].id;
      end
      tick();
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      req_vld = '0;
      for (int r = 0; r < 3; r++) req[r] = '0;
      #1;
      check_eq("reset_wbv", wbv, 2'b00);
      check_eq("reset_rdy", req_rdy, 3'b111);
      check_eq("reset_src", wb_src, 4'h0);
      check_eq("reset_wb0", wb[0], 45'd0);
      tick();
      tick();
      rst = 1'b0;

      // Single requester
      drive(2, 1'b1, 8'd7, 32'hA5);
      tick();
      req_vld = '0;
      check_eq("single_lat1_wbv", wbv, 2'b00);
      tick();
      check_eq("single_wbv", wbv, 2'b01);
      check_eq("single_data", wb[0].data, 32'hA5);
      check_eq("single_id", wb[0].id, 8'd7);
      check_eq("single_src", wb_src[0], 2'd2);
      check_eq("single_port1", wb[1], 45'd0);
      tick();
      check_eq("single_after_wbv", wbv, 2'b00);

      // Contention with backpressure: all three held valid
      cur[0] = 8'h00; cur[1] = 8'h10; cur[2] = 8'h20;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) for (int r = 0; r < 3; r++) if (c_rdy[k-1][r]) cur[r]++;
         for (int r = 0; r < 3; r++) drive(r, 1'b1, cur[r], {24'd0, cur[r]});
         check_eq($sformatf("cont_rdy_%0d", k), req_rdy, c_rdy[k]);
         check_eq($sformatf("cont_wbv_%0d", k), wbv, c_wbv[k]);
         if (k >= 2) begin
            check_eq($sformatf("cont_src0_%0d", k), wb_src[0], c_s0[k]);
            check_eq($sformatf("cont_src1_%0d", k), wb_src[1], c_s1[k]);
            check_eq($sformatf("cont_id0_%0d", k), wb[0].id, c_id0[k]);
            check_eq($sformatf("cont_id1_%0d", k), wb[1].id, c_id1[k]);
         end
         if (k < 5) tick();
      end

      // Asynchronous reset with all slots full
      #2;
      rst     = 1'b1;
      req_vld = '0;
      #1;
      check_eq("midrst_wbv", wbv, 2'b00);
      check_eq("midrst_rdy", req_rdy, 3'b111);
      check_eq("midrst_src", wb_src, 4'h0);
      check_eq("midrst_wb0", wb[0], 45'd0);
      tick();
      rst = 1'b0;
      for (int r = 0; r < 3; r++) drive(r, 1'b1, 8'h30 + 8'(r), 32'h300 + 32'(r));
      tick();
      req_vld = '0;
      check_eq("postrst_lat_wbv", wbv, 2'b00);
      tick();
      check_eq("postrst_wbv1", wbv, 2'b11);
      check_eq("postrst_src0", wb_src[0], 2'd0);
      check_eq("postrst_src1", wb_src[1], 2'd1);
      tick();
      check_eq("postrst_wbv2", wbv, 2'b01);
      check_eq("postrst_src2", wb_src[0], 2'd2);
      tick();

      // Flush with slots 0 and 1 full and a new request on 2
      drive(0, 1'b1, 8'h40, 32'h40);
      drive(1, 1'b1, 8'h41, 32'h41);
      tick();
      req_vld = '0;
      flush   = 1'b1;
      drive(2, 1'b1, 8'h77, 32'h77);
      check_eq("flush_rdy", req_rdy, 3'b111);
      tick();
      flush   = 1'b0;
      req_vld = '0;
      check_eq("flush_wbv", wbv, 2'b00);
      check_eq("flush_slots_empty", req_rdy, 3'b111);
      tick();
      check_eq("flush_drop_req2", wbv, 2'b00);
      for (int r = 0; r < 3; r++) drive(r, 1'b1, 8'h50 + 8'(r), 32'h50);
      tick();
      req_vld = '0;
      tick();
      check_eq("flush_ptr_wbv", wbv, 2'b11);
      check_eq("flush_ptr_src0", wb_src[0], 2'd0);
      check_eq("flush_ptr_src1", wb_src[1], 2'd1);
      tick();
      check_eq("flush_ptr_src2", wb_src[0], 2'd2);
      tick();

      // Random traffic with scoreboard and fairness bound
      for (int r = 0; r < 3; r++) begin
         pend[r] = 1'b0; age[r] = 0; acc[r] = 1'b0; acc_id[r] = '0; seq[r] = '0;
      end
      req_vld = '0;
      for (int c = 0; c < 10000; c++) rnd_step(1'b1);
      for (int c = 0; c < 5; c++) rnd_step(1'b0);
      for (int r = 0; r < 3; r++) check_eq($sformatf("rnd_lost_%0d", r), {63'd0, pend[r]}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
